// File: rtl/ysyx_22050078_mdu_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit:
// op codes driven by the decoder and the controller state encoding.
package ysyx_22050078_mdu_pkg;

    localparam int unsigned MDU_OP_W = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MUL    = 4'd0,
        MDU_MULH   = 4'd1,
        MDU_MULHSU = 4'd2,
        MDU_MULHU  = 4'd3,
        MDU_DIV    = 4'd4,
        MDU_DIVU   = 4'd5,
        MDU_REM    = 4'd6,
        MDU_REMU   = 4'd7,
        MDU_MULW   = 4'd8,
        MDU_DIVW   = 4'd9,
        MDU_DIVUW  = 4'd10,
        MDU_REMW   = 4'd11,
        MDU_REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/ysyx_22050078_mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module ysyx_22050078_mdu_divstep #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_dsr,
    input  logic            i_bit,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The running remainder is always below the divisor, so the top bit of
    // the trial difference is a clean borrow flag.
    always_comb begin
        shifted = {i_rem, i_bit};
        diff    = shifted - {1'b0, i_dsr};
        o_q     = ~diff[XLEN];
        o_rem   = o_q ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/ysyx_22050078_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring
// division on operand magnitudes, one bit per cycle, with sign fix at the end.
module ysyx_22050078_mdu
    import ysyx_22050078_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [OP_W-1:0] i_op,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res,
    output logic            o_busy
);

    localparam int unsigned     CW     = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ONES   = '1;
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic signed [31:0] MIN32 = 32'sh8000_0000;
    localparam logic [XLEN-1:0] MIN_W  = XLEN'(MIN32);

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mul_q, mul_d, w_q, w_d, hi_q, hi_d, rem_q, rem_d, neg_q, neg_d;
    logic [XLEN-1:0]   opa_q, opa_d;   // multiplier, or dividend shifting into quotient
    logic [2*XLEN-1:0] opb_q, opb_d;   // multiplicand shifting left, or divisor
    logic [2*XLEN-1:0] acc_q, acc_d;   // product, or partial remainder
    logic [XLEN-1:0]   res_q, res_d;

    mdu_op_e         in_op;
    logic            in_ill, in_w, in_mul, in_hi, in_rem, s1_sgn, s2_sgn;
    logic            n1, n2, div0, ovf, special;
    logic [XLEN-1:0] x1, x2, m1, m2, sp_res;

    logic [XLEN-1:0]   dv_rem;
    logic              dv_q;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rv;

    always_comb begin
        in_op  = mdu_op_e'(MDU_OP_W'(i_op));
        in_ill = (32'(i_op) > 32'(MDU_REMUW));
        in_w   = in_op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
        in_mul = in_op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_MULW};
        in_hi  = in_op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
        in_rem = in_op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
        s1_sgn = in_op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
        s2_sgn = in_op inside {MDU_MULH, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
        if (in_w) begin
            x1 = s1_sgn ? XLEN'(signed'(i_src1[31:0])) : XLEN'(i_src1[31:0]);
            x2 = s2_sgn ? XLEN'(signed'(i_src2[31:0])) : XLEN'(i_src2[31:0]);
        end else begin
            x1 = i_src1;
            x2 = i_src2;
        end
        n1   = s1_sgn & x1[XLEN-1];
        n2   = s2_sgn & x2[XLEN-1];
        m1   = n1 ? -x1 : x1;
        m2   = n2 ? -x2 : x2;
        div0 = !in_mul && (x2 == '0);
        ovf  = !in_mul && s2_sgn && (x1 == (in_w ? MIN_W : MIN_X)) && (x2 == ONES);
        special = in_ill || (in_w && (XLEN == 32)) || div0 || ovf;
        if (in_ill || (in_w && (XLEN == 32))) sp_res = '0;
        else if (div0)                        sp_res = in_rem ? x1 : ONES;
        else                                  sp_res = in_rem ? '0 : x1;
        if (in_w) sp_res = XLEN'(signed'(sp_res[31:0]));
    end

    ysyx_22050078_mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .i_rem (acc_q[XLEN-1:0]),
        .i_dsr (opb_q[XLEN-1:0]),
        .i_bit (opa_q[XLEN-1]),
        .o_rem (dv_rem),
        .o_q   (dv_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        w_d     = w_q;
        hi_d    = hi_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        prod    = '0;
        rv      = '0;
        unique case (state_q)
            IDLE: if (i_valid) begin
                mul_d = in_mul;
                w_d   = in_w;
                hi_d  = in_hi;
                rem_d = in_rem;
                neg_d = in_rem ? n1 : (n1 ^ n2);
                cnt_d = '0;
                acc_d = '0;
                if (special) begin
                    res_d   = sp_res;
                    state_d = DONE;
                end else begin
                    // W divides feed the 32-bit dividend MSB-first from the top.
                    opa_d   = in_mul ? m2 : (in_w ? m1 << (XLEN - 32) : m1);
                    opb_d   = (2*XLEN)'(in_mul ? m1 : m2);
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (mul_q) begin
                    acc_d = opa_q[0] ? acc_q + opb_q : acc_q;
                    opb_d = opb_q << 1;
                    opa_d = opa_q >> 1;
                end else begin
                    acc_d = (2*XLEN)'(dv_rem);
                    opa_d = {opa_q[XLEN-2:0], dv_q};
                end
                if (cnt_q == (w_q ? CW'(31) : CW'(XLEN - 1))) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (mul_q) begin
                        prod = neg_q ? -acc_d : acc_d;
                        rv   = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                    end else begin
                        rv   = rem_q ? acc_d[XLEN-1:0] : opa_d;
                        rv   = neg_q ? -rv : rv;
                    end
                    res_d = w_q ? XLEN'(signed'(rv[31:0])) : rv;
                end
            end
            DONE: if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            w_q     <= 1'b0;
            hi_q    <= 1'b0;
            rem_q   <= 1'b0;
            neg_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            w_q     <= w_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_valid = (state_q == DONE);
    assign o_res   = res_q;

endmodule
